// File: rtl/keypad_scan_reader.sv
// rtl/keypad_scan_reader.sv - 4x4 matrix keypad row scanner with whole-matrix debounce
// Drives one row low per slot, snapshots the columns, and reports single-key presses with n-key lockout.
module keypad_scan_reader #(
    parameter int SCAN_DIV       = 12500,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] key_row,
    input  logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_N     = 4'(DEBOUNCE_SCANS);

    typedef enum logic {IDLE, HELD} state_t;

    logic [3:0]       r_col_meta;
    logic [3:0]       r_col_sync;
    logic [CNT_W-1:0] r_slot_cnt;
    logic [1:0]       r_row_idx;
    logic [15:0]      r_snap;
    logic [15:0]      r_prev;
    logic [15:0]      r_deb;
    logic [3:0]       r_stable_cnt;
    logic             r_deb_upd;
    state_t           r_state;
    logic [3:0]       r_key_row;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;
    logic             r_multi_key;

    logic             w_slot_end;
    logic [15:0]      w_snap_full;
    logic [4:0]       w_deb_cnt;
    logic [3:0]       w_deb_idx;

    assign w_slot_end = (r_slot_cnt == SLOT_LAST);

    // Snapshot including the row being sampled this slot; the bit index helper reports the lowest set bit.
    always_comb begin
        w_snap_full = r_snap;
        w_snap_full[{r_row_idx, 2'b00} +: 4] = ~r_col_sync;
        w_deb_cnt = '0;
        w_deb_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (r_deb[i]) begin
                w_deb_cnt = w_deb_cnt + 5'd1;
                w_deb_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_meta <= 4'hF;
            r_col_sync <= 4'hF;
        end else begin
            r_col_meta <= key_col;
            r_col_sync <= r_col_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt   <= '0;
            r_row_idx    <= '0;
            r_key_row    <= 4'b1110;
            r_snap       <= '0;
            r_prev       <= '0;
            r_deb        <= '0;
            r_stable_cnt <= '0;
            r_deb_upd    <= 1'b0;
        end else begin
            r_deb_upd <= 1'b0;
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_row_idx  <= r_row_idx + 2'd1;
                r_key_row  <= ~(4'b0001 << (r_row_idx + 2'd1));
                if (r_row_idx == 2'd3) begin
                    r_snap <= '0;
                    r_prev <= w_snap_full;
                    if (w_snap_full == r_prev) begin
                        // Debounced state is taken once, on the scan that completes the stable run.
                        if (r_stable_cnt != DEB_N) begin
                            r_stable_cnt <= r_stable_cnt + 4'd1;
                            if (r_stable_cnt + 4'd1 == DEB_N) begin
                                r_deb     <= w_snap_full;
                                r_deb_upd <= 1'b1;
                            end
                        end
                    end else begin
                        r_stable_cnt <= '0;
                    end
                end else begin
                    r_snap <= w_snap_full;
                end
            end else begin
                r_slot_cnt <= r_slot_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_multi_key <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_deb_upd) begin
                case (r_state)
                    IDLE: begin
                        if (w_deb_cnt == 5'd1) begin
                            r_key_code  <= w_deb_idx;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_state     <= HELD;
                        end else if (w_deb_cnt >= 5'd2) begin
                            r_multi_key <= 1'b1;
                            r_key_held  <= 1'b1;
                            r_state     <= HELD;
                        end
                    end
                    HELD: begin
                        // Lockout: only a full release re-arms key_valid.
                        if (w_deb_cnt == 5'd0) begin
                            r_key_held  <= 1'b0;
                            r_multi_key <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_multi_key <= (w_deb_cnt >= 5'd2);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign key_row   = r_key_row;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
    assign multi_key = r_multi_key;

endmodule

// File: tb/tb_keypad_scan_reader.sv
// tb/tb_keypad_scan_reader.sv - directed bench for keypad_scan_reader with a scan-level reference model
// The model derives outputs from slot arithmetic and scan run lengths; directed checks pin latency and codes.
module tb_keypad_scan_reader;

    localparam int SD = 8;
    localparam int DS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic        multi_key;
    logic [15:0] pressed = '0;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int cyc     = 0;

    keypad_scan_reader #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
    end

    always @(posedge clk) cyc++;
    always @(negedge clk) if (key_valid) n_valid++;

    // Reference model: edge count since reset gives slot/row; debounce is a run length of equal scans.
    int          m_e = 0;
    int          m_run = 1;
    int          m_row;
    int          m_n;
    bit          m_upd = 0;
    bit          m_held = 0;
    logic [15:0] m_snap = '0, m_last = '0, m_deb = '0, m_h1 = '0, m_h2 = '0;
    logic [3:0]  exp_row = 4'b1110;
    logic [3:0]  exp_code = '0;
    logic        exp_valid = 0, exp_held = 0, exp_multi = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_e = 0; m_run = 1; m_upd = 0; m_held = 0;
            m_snap = '0; m_last = '0; m_deb = '0; m_h1 = '0; m_h2 = '0;
            exp_row = 4'b1110; exp_code = '0; exp_valid = 0; exp_held = 0; exp_multi = 0;
        end else begin
            m_e++;
            exp_valid = 0;
            if (m_upd) begin
                m_upd = 0;
                m_n = $countones(m_deb);
                if (!m_held) begin
                    if (m_n == 1) begin
                        exp_code = 4'($clog2(m_deb)); exp_valid = 1; exp_held = 1; m_held = 1;
                    end else if (m_n >= 2) begin
                        exp_multi = 1; exp_held = 1; m_held = 1;
                    end
                end else if (m_n == 0) begin
                    m_held = 0; exp_held = 0; exp_multi = 0;
                end else begin
                    exp_multi = (m_n >= 2);
                end
            end
            if (m_e % SD == 0) begin
                m_row = (m_e / SD - 1) % 4;
                m_snap[m_row*4 +: 4] = m_h2[m_row*4 +: 4];
                if (m_row == 3) begin
                    if (m_snap == m_last) m_run++;
                    else m_run = 1;
                    m_last = m_snap;
                    if (m_run == DS + 1) begin
                        m_deb = m_snap; m_upd = 1;
                    end
                end
            end
            m_h2 = m_h1;
            m_h1 = pressed;
            exp_row = ~(4'b0001 << ((m_e / SD) % 4));
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({key_row, key_code, key_valid, key_held, multi_key} !== {exp_row, exp_code, exp_valid, exp_held, exp_multi}) begin
            n_err++;
            $display("FAIL model cyc=%0d: got row=%b code=%h v=%b h=%b m=%b, want row=%b code=%h v=%b h=%b m=%b",
                     cyc, key_row, key_code, key_valid, key_held, multi_key,
                     exp_row, exp_code, exp_valid, exp_held, exp_multi);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // sel: 0 key_valid high, 1 key_held low, 2 multi_key high, 3 multi_key low; lat=-1 on timeout
    task automatic wait_ev(input int sel, input int t_start, input int limit, output int lat);
        lat = -1;
        for (int i = 0; i < limit && lat < 0; i++) begin
            @(negedge clk);
            if ((sel == 0 && key_valid) || (sel == 1 && !key_held) ||
                (sel == 2 && multi_key) || (sel == 3 && !multi_key))
                lat = cyc - t_start;
        end
    endtask

    logic [3:0] row_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int t0, lat, v0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_row", key_row, 4'b1110);
        chk("rst_code", key_code, 0);
        chk("rst_flags", {key_valid, key_held, multi_key}, 0);
        rst = 1'b0;

        // 1: idle scanning
        chk("s1_row_0", key_row, 4'b1110);
        for (int i = 1; i <= 4; i++) begin
            repeat (SD) @(negedge clk);
            chk($sformatf("s1_row_%0d", i), key_row, row_tab[i % 4]);
        end
        repeat (150) @(negedge clk);
        chk("s1_no_valid", n_valid, 0);
        chk("s1_held", key_held, 0);

        // 2: single key (2,1)
        v0 = n_valid;
        pressed[9] = 1'b1; t0 = cyc;
        wait_ev(0, t0, 200, lat);
        chk_rng("s2_press_latency", lat, 96, 164);
        chk("s2_code", key_code, 9);
        while (cyc - t0 < 400) @(negedge clk);
        pressed[9] = 1'b0; t0 = cyc;
        wait_ev(1, t0, 200, lat);
        chk_rng("s2_release_latency", lat, 96, 164);
        chk("s2_code_kept", key_code, 9);
        chk("s2_one_pulse", n_valid, v0 + 1);

        // 3: bouncing (0,3)
        v0 = n_valid;
        for (int i = 0; i < 150; i++) begin
            pressed[3] = ((i / 20) % 2 == 0);
            @(negedge clk);
        end
        chk("s3_no_valid_bounce", n_valid, v0);
        pressed[3] = 1'b1; t0 = cyc;
        wait_ev(0, t0, 250, lat);
        chk_rng("s3_valid_after_stable", lat, 0, 200);
        chk("s3_code", key_code, 3);
        pressed = '0; t0 = cyc;
        wait_ev(1, t0, 200, lat);
        chk_rng("s3_release", lat, 96, 164);
        chk("s3_one_pulse", n_valid, v0 + 1);

        // 4: two keys together, then (3,3) alone
        v0 = n_valid;
        pressed = 16'h8010; t0 = cyc;
        wait_ev(2, t0, 200, lat);
        chk_rng("s4_multi_latency", lat, 96, 164);
        chk("s4_held", key_held, 1);
        chk("s4_code_unchanged", key_code, 3);
        pressed = '0; t0 = cyc;
        wait_ev(1, t0, 200, lat);
        chk_rng("s4_release", lat, 96, 164);
        chk("s4_multi_clear", multi_key, 0);
        chk("s4_no_valid", n_valid, v0);
        pressed[15] = 1'b1; t0 = cyc;
        wait_ev(0, t0, 200, lat);
        chk_rng("s4_single_latency", lat, 96, 164);
        chk("s4_code_f", key_code, 15);
        pressed = '0; t0 = cyc;
        wait_ev(1, t0, 200, lat);
        chk("s4_one_pulse", n_valid, v0 + 1);

        // 5: n-key lockout
        v0 = n_valid;
        pressed[0] = 1'b1; t0 = cyc;
        wait_ev(0, t0, 200, lat);
        chk_rng("s5_first_latency", lat, 96, 164);
        chk("s5_code", key_code, 0);
        repeat (40) @(negedge clk);
        pressed[5] = 1'b1; t0 = cyc;
        wait_ev(2, t0, 200, lat);
        chk_rng("s5_multi_rise", lat, 96, 164);
        pressed[0] = 1'b0; t0 = cyc;
        wait_ev(3, t0, 200, lat);
        chk_rng("s5_multi_fall", lat, 96, 164);
        chk("s5_still_held", key_held, 1);
        pressed = '0; t0 = cyc;
        wait_ev(1, t0, 200, lat);
        chk_rng("s5_release", lat, 96, 164);
        chk("s5_one_pulse", n_valid, v0 + 1);

        // 6: reset mid-debounce with (2,2) held
        v0 = n_valid;
        pressed[10] = 1'b1;
        repeat (64) @(negedge clk);
        chk("s6_no_valid_yet", n_valid, v0);
        #2 rst = 1'b1;
        #1;
        chk("s6_rst_row", key_row, 4'b1110);
        chk("s6_rst_outputs", {key_code, key_valid, key_held, multi_key}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0; t0 = cyc;
        wait_ev(0, t0, 250, lat);
        chk_rng("s6_redebounce_latency", lat, 128, 164);
        chk("s6_code", key_code, 10);
        pressed = '0; t0 = cyc;
        wait_ev(1, t0, 200, lat);
        chk("s6_one_pulse", n_valid, v0 + 1);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
